// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the 32x64 register file: WB has priority, and NIC writes queue in a FIFO.
// Optional statistics counters are enabled with `define RF_ARB_STATS_EN.
module rf_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_wr_en,
    input  logic [4:0]        wb_rd,
    input  logic [2:0]        wb_ppp,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              nic_valid,
    output logic              nic_ready,
    input  logic [4:0]        nic_rd,
    input  logic [2:0]        nic_ppp,
    input  logic [DATA_W-1:0] nic_data,
    output logic              rf_wrEn,
    output logic [4:0]        rf_rD,
    output logic [2:0]        rf_ppp,
    output logic [DATA_W-1:0] rf_d_in,
    output logic [31:0]       pending_mask,
    output logic              proto_err
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]       stat_wb_grants,
    output logic [31:0]       stat_nic_grants,
    output logic [31:0]       stat_starve_events
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]        rd;
        logic [2:0]        ppp;
        logic [DATA_W-1:0] data;
    } nic_entry_t;

    nic_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             perr_q, perr_d;

    logic       fifo_empty;
    logic       fifo_full;
    logic       wb_grant;
    logic       pop;
    logic       push;
    logic       starve_inc;
    nic_entry_t head;

    // Grants are gated by reset so the RF port stays quiet while reset is held,
    // even if the pipeline keeps driving wb_wr_en.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        head       = mem_q[rd_ptr_q];
        wb_grant   = wb_wr_en && reset;
        pop        = reset && !wb_wr_en && !fifo_empty;
        push       = reset && nic_valid && !fifo_full;
        starve_inc = wb_grant && !fifo_empty;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rf_wrEn = 1'b0;
        rf_rD   = '0;
        rf_ppp  = '0;
        rf_d_in = '0;
        if (wb_grant) begin
            rf_wrEn = 1'b1;
            rf_rD   = wb_rd;
            rf_ppp  = wb_ppp;
            rf_d_in = wb_data;
        end else if (pop) begin
            rf_wrEn = 1'b1;
            rf_rD   = head.rd;
            rf_ppp  = head.ppp;
            rf_d_in = head.data;
        end
    end

    assign nic_ready = reset && !fifo_full;
    assign wb_stall  = stall_q;
    assign proto_err = perr_q;

    // Valid entries are the count_q slots starting at the head; the popping head is still included.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pending_mask[mem_q[rd_ptr_q + PTR_W'(i)].rd] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Starvation: count cycles the head is blocked by WB; stall WB once the limit is reached.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        perr_d   = perr_q | (wb_wr_en & stall_q);
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_inc && (starve_q != STV_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_inc && (starve_d == STV_MAX)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            perr_q   <= perr_d;
        end
    end

    // NOTE: the entry storage is not reset; validity comes only from count_q and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: nic_rd, ppp: nic_ppp, data: nic_data};
        end
    end

`ifdef RF_ARB_STATS_EN
    logic [31:0] wb_cnt_q, nic_cnt_q, stv_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_cnt_q  <= '0;
            nic_cnt_q <= '0;
            stv_cnt_q <= '0;
        end else begin
            if (wb_grant && (wb_cnt_q != '1)) begin
                wb_cnt_q <= wb_cnt_q + 1'b1;
            end
            if (pop && (nic_cnt_q != '1)) begin
                nic_cnt_q <= nic_cnt_q + 1'b1;
            end
            if (stall_d && !stall_q && (stv_cnt_q != '1)) begin
                stv_cnt_q <= stv_cnt_q + 1'b1;
            end
        end
    end

    assign stat_wb_grants     = wb_cnt_q;
    assign stat_nic_grants    = nic_cnt_q;
    assign stat_starve_events = stv_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus random traffic against a queue model.
module tb_rf_wr_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int DW    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wb_wr_en;
    logic [4:0]    wb_rd;
    logic [2:0]    wb_ppp;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          nic_valid;
    logic          nic_ready;
    logic [4:0]    nic_rd;
    logic [2:0]    nic_ppp;
    logic [DW-1:0] nic_data;
    logic          rf_wrEn;
    logic [4:0]    rf_rD;
    logic [2:0]    rf_ppp;
    logic [DW-1:0] rf_d_in;
    logic [31:0]   pending_mask;
    logic          proto_err;
`ifdef RF_ARB_STATS_EN
    logic [31:0]   stat_wb_grants;
    logic [31:0]   stat_nic_grants;
    logic [31:0]   stat_starve_events;
`endif

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_ppp(wb_ppp), .wb_data(wb_data),
        .wb_stall(wb_stall),
        .nic_valid(nic_valid), .nic_ready(nic_ready), .nic_rd(nic_rd),
        .nic_ppp(nic_ppp), .nic_data(nic_data),
        .rf_wrEn(rf_wrEn), .rf_rD(rf_rD), .rf_ppp(rf_ppp), .rf_d_in(rf_d_in),
        .pending_mask(pending_mask), .proto_err(proto_err)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_wb_grants(stat_wb_grants), .stat_nic_grants(stat_nic_grants),
        .stat_starve_events(stat_starve_events)
`endif
    );

    // Reference model: queued NIC writes in acceptance order, plus starvation state.
    typedef struct {
        logic [4:0]    rd;
        logic [2:0]    ppp;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_cnt   = 0;
    bit   m_stall = 1'b0;
    bit   m_perr  = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   stall_at;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt   = 0;
        m_stall = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic check_outputs();
        logic          exp_en;
        logic [4:0]    exp_rd;
        logic [2:0]    exp_ppp;
        logic [DW-1:0] exp_d;
        logic [31:0]   exp_mask;
        logic          exp_rdy;
        exp_en   = 1'b0;
        exp_rd   = '0;
        exp_ppp  = '0;
        exp_d    = '0;
        exp_mask = '0;
        if (reset && wb_wr_en) begin
            exp_en  = 1'b1;
            exp_rd  = wb_rd;
            exp_ppp = wb_ppp;
            exp_d   = wb_data;
        end else if (reset && mq.size() > 0) begin
            exp_en  = 1'b1;
            exp_rd  = mq[0].rd;
            exp_ppp = mq[0].ppp;
            exp_d   = mq[0].data;
        end
        foreach (mq[i]) exp_mask[mq[i].rd] = 1'b1;
        exp_rdy = reset && (mq.size() < DEPTH);
        check("rf_wrEn", rf_wrEn, exp_en);
        check("rf_rD", rf_rD, exp_rd);
        check("rf_ppp", rf_ppp, exp_ppp);
        check("rf_d_in", rf_d_in, exp_d);
        check("pending_mask", pending_mask, exp_mask);
        check("nic_ready", nic_ready, exp_rdy);
        check("wb_stall", wb_stall, m_stall);
        check("proto_err", proto_err, m_perr);
    endtask

    task automatic model_edge();
        bit   was_empty;
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (!reset) begin
            model_reset();
            return;
        end
        was_empty = (mq.size() == 0);
        do_pop    = !wb_wr_en && !was_empty;
        do_push   = nic_valid && (mq.size() < DEPTH);
        if (wb_wr_en && m_stall) m_perr = 1'b1;
        if (do_pop) begin
            void'(mq.pop_front());
            m_cnt   = 0;
            m_stall = 1'b0;
        end else if (was_empty) begin
            m_cnt = 0;
        end else begin
            if (m_cnt < LIMIT) m_cnt++;
            if (m_cnt == LIMIT) m_stall = 1'b1;
        end
        if (do_push) begin
            e.rd   = nic_rd;
            e.ppp  = nic_ppp;
            e.data = nic_data;
            mq.push_back(e);
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model at the edge, return just after it.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [2:0] ppp,
                          input logic [63:0] d);
        wb_wr_en = en;
        wb_rd    = rd;
        wb_ppp   = ppp;
        wb_data  = d;
    endtask

    task automatic set_nic(input logic v, input logic [4:0] rd, input logic [2:0] ppp,
                           input logic [63:0] d);
        nic_valid = v;
        nic_rd    = rd;
        nic_ppp   = ppp;
        nic_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        #2;
        check("rst_hold_wrEn", rf_wrEn, 1'b0);
        check("rst_hold_ready", nic_ready, 1'b0);
        set_wb(1'b1, 5'd3, 3'd1, 64'hAB);
        #1;
        check("rst_gate_wrEn", rf_wrEn, 1'b0);
        check("rst_gate_rd", rf_rD, 5'd0);
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        check("idle_ready", nic_ready, 1'b1);
        check("idle_wrEn", rf_wrEn, 1'b0);
        check("idle_mask", pending_mask, 32'd0);
        check("idle_stall", wb_stall, 1'b0);
        cycle();

        // Single NIC write: one cycle of latency, no bypass.
        set_nic(1'b1, 5'd5, 3'd0, 64'h1122334455667788);
        cycle();
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        #1;
        check("nic1_wrEn", rf_wrEn, 1'b1);
        check("nic1_rd", rf_rD, 5'd5);
        check("nic1_data", rf_d_in, 64'h1122334455667788);
        check("nic1_mask", pending_mask, 32'h0000_0020);
        cycle();
        check("nic1_mask_clr", pending_mask, 32'd0);
        check("nic1_idle", rf_wrEn, 1'b0);

        // Fill under continuous WB, wait for starvation stall, then drain in order.
        for (int k = 0; k < 4; k++) begin
            set_wb(1'b1, 5'(20 + k), 3'd7, {$urandom, $urandom});
            set_nic(1'b1, 5'(k + 1), 3'(k), {$urandom, $urandom});
            cycle();
        end
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        #1;
        check("full_ready", nic_ready, 1'b0);
        stall_at = 0;
        for (int k = 4; k <= 14 && stall_at == 0; k++) begin
            if (wb_stall) begin
                stall_at = k;
            end else begin
                set_wb(1'b1, 5'($urandom_range(0, 31)), 3'd1, {$urandom, $urandom});
                cycle();
            end
        end
        check("stall_rise_cycle", 64'(stall_at), 64'd9);
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        for (int r = 1; r <= 4; r++) begin
            #1;
            check("drain_wrEn", rf_wrEn, 1'b1);
            check("drain_order", rf_rD, 5'(r));
            cycle();
            if (r == 1) check("stall_clr", wb_stall, 1'b0);
        end
        check("drain_mask", pending_mask, 32'd0);

        // WB beats a non-empty FIFO; the head waits for the next idle cycle.
        set_nic(1'b1, 5'd9, 3'd2, 64'hCAFE_F00D_0000_0009);
        cycle();
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        set_wb(1'b1, 5'd7, 3'b011, 64'hDEAD_BEEF_0000_0007);
        #1;
        check("prio_rd", rf_rD, 5'd7);
        check("prio_ppp", rf_ppp, 3'b011);
        check("prio_data", rf_d_in, 64'hDEAD_BEEF_0000_0007);
        check("prio_mask", pending_mask, 32'h0000_0200);
        cycle();
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        #1;
        check("held_rd", rf_rD, 5'd9);
        check("held_ppp", rf_ppp, 3'd2);
        cycle();
        check("held_popped", pending_mask, 32'd0);

        // Protocol violation: WB keeps writing while stalled.
        set_nic(1'b1, 5'd11, 3'd1, {$urandom, $urandom});
        cycle();
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        for (int k = 1; k <= 12 && !wb_stall; k++) begin
            set_wb(1'b1, 5'd2, 3'd0, {$urandom, $urandom});
            cycle();
        end
        check("stall2", wb_stall, 1'b1);
        set_wb(1'b1, 5'd13, 3'd4, 64'h0123_4567_89AB_CDEF);
        #1;
        check("viol_grant", rf_rD, 5'd13);
        check("viol_wrEn", rf_wrEn, 1'b1);
        cycle();
        check("perr_set", proto_err, 1'b1);
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        for (int k = 0; k < 3; k++) cycle();
        check("perr_sticky", proto_err, 1'b1);
        check("stall2_clr", wb_stall, 1'b0);

        // Async reset mid-drain with three entries still queued.
        for (int k = 0; k < 4; k++) begin
            set_wb(1'b1, 5'd30, 3'd5, {$urandom, $urandom});
            set_nic(1'b1, 5'(16 + k), 3'(k), {$urandom, $urandom});
            cycle();
        end
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        cycle();
        set_wb(1'b1, 5'd31, 3'd7, 64'hFFFF_0000_FFFF_0000);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_wrEn", rf_wrEn, 1'b0);
        check("arst_rd", rf_rD, 5'd0);
        check("arst_ppp", rf_ppp, 3'd0);
        check("arst_data", rf_d_in, 64'd0);
        check("arst_mask", pending_mask, 32'd0);
        check("arst_ready", nic_ready, 1'b0);
        check("arst_perr", proto_err, 1'b0);
        check("arst_stall", wb_stall, 1'b0);
        cycle();
        cycle();
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_mask", pending_mask, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("no_stale_wr", rf_wrEn, 1'b0);
        end

        // Random traffic; the pipeline mostly honours wb_stall.
        for (int i = 0; i < 400; i++) begin
            if (wb_stall) set_wb(($urandom_range(0, 49) == 0), 5'($urandom_range(0, 31)),
                                 3'($urandom_range(0, 7)), {$urandom, $urandom});
            else          set_wb(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)),
                                 3'($urandom_range(0, 7)), {$urandom, $urandom});
            set_nic(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                    3'($urandom_range(0, 7)), {$urandom, $urandom});
            cycle();
        end
        set_wb(1'b0, 5'd0, 3'd0, 64'd0);
        set_nic(1'b0, 5'd0, 3'd0, 64'd0);
        for (int k = 0; k < DEPTH + 2; k++) cycle();
        check("final_mask", pending_mask, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
